// File: rtl/alu_exec_cdb_pkg.sv
// alu_exec_cdb_pkg: widths, free tag and ALU opcodes shared with the reservation station and decoder
package alu_exec_cdb_pkg;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int NAME_W = 5;
  localparam int OP_W   = 5;
  localparam int DEPTH  = 4;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] FREE_TAG = '0;
  localparam logic [OP_W-1:0] OP_NOP  = 5'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd2;
  localparam logic [OP_W-1:0] OP_SLL  = 5'd3;
  localparam logic [OP_W-1:0] OP_SLT  = 5'd4;
  localparam logic [OP_W-1:0] OP_SLTU = 5'd5;
  localparam logic [OP_W-1:0] OP_XOR  = 5'd6;
  localparam logic [OP_W-1:0] OP_SRL  = 5'd7;
  localparam logic [OP_W-1:0] OP_SRA  = 5'd8;
  localparam logic [OP_W-1:0] OP_OR   = 5'd9;
  localparam logic [OP_W-1:0] OP_AND  = 5'd10;
  localparam logic [OP_W-1:0] OP_LUI  = 5'd11;
  localparam logic [OP_W-1:0] OP_PASS = 5'd12;
endpackage

// File: rtl/alu_exec_cdb_alu_core.sv
// alu_core: combinational ALU, op/a/b to result; undefined opcodes yield zero
module alu_core
  import alu_exec_cdb_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);
  // select the operation result; shift amount is the low five bits of b
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLL:  result = a << b[4:0];
      OP_SRL:  result = a >> b[4:0];
      OP_SRA:  result = $signed(a) >>> b[4:0];
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: result = {{(DATA_W-1){1'b0}}, a < b};
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LUI:  result = b;
      OP_PASS: result = b;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/alu_exec_cdb.sv
// alu_exec_cdb: ALU execute stage with in-order result queue and CDB request/grant broadcast
module alu_exec_cdb
  import alu_exec_cdb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_opnd_a,
  input  logic [DATA_W-1:0] in_opnd_b,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [NAME_W-1:0] in_name,
  output logic              in_ready,
  input  logic              flush,
  output logic              cdb_req,
  input  logic              cdb_gnt,
  output logic              cdb_en,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [NAME_W-1:0] cdb_name,
  output logic [DATA_W-1:0] cdb_data
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [NAME_W-1:0] name_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [AW-1:0]     head, tail;
  logic [AW:0]       count;
  logic [DATA_W-1:0] alu_res;
  logic              push, pop;
  alu_core u_alu (
    .op     (in_op),
    .a      (in_opnd_a),
    .b      (in_opnd_b),
    .result (alu_res)
  );
  assign in_ready = count != FULL;
  assign cdb_req  = count != '0;
  assign cdb_en   = cdb_req & cdb_gnt & ~flush;
  assign push     = in_valid & in_ready & ~flush & (in_op != OP_NOP) & (in_tag != FREE_TAG);
  assign pop      = cdb_en;
  assign cdb_tag  = cdb_req ? tag_q[head]  : FREE_TAG;
  assign cdb_name = cdb_req ? name_q[head] : '0;
  assign cdb_data = cdb_req ? data_q[head] : '0;
  // queue storage and pointers; flush outranks push and pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= FREE_TAG;
        name_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tag_q[tail]  <= in_tag;
        name_q[tail] <= in_name;
        data_q[tail] <= alu_res;
        tail         <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= (push & ~pop) ? count + 1'b1 : (~push & pop) ? count - 1'b1 : count;
    end
  end
endmodule

// File: tb/tb_alu_exec_cdb.sv
// tb_alu_exec_cdb: directed scoreboard bench for the ALU execute / CDB stage
module tb_alu_exec_cdb;
  import alu_exec_cdb_pkg::*;
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [NAME_W-1:0] name;
    logic [DATA_W-1:0] data;
  } exp_t;
  logic clk = 0, rst = 0, in_valid = 0, flush = 0, cdb_gnt = 0;
  logic [OP_W-1:0]   in_op = '0;
  logic [DATA_W-1:0] in_opnd_a = '0, in_opnd_b = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic [NAME_W-1:0] in_name = '0;
  logic in_ready, cdb_req, cdb_en;
  logic [TAG_W-1:0]  cdb_tag;
  logic [NAME_W-1:0] cdb_name;
  logic [DATA_W-1:0] cdb_data;
  exp_t sb[$];
  int n_checks = 0, n_fail = 0;
  alu_exec_cdb dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op),
    .in_opnd_a(in_opnd_a), .in_opnd_b(in_opnd_b), .in_tag(in_tag), .in_name(in_name),
    .in_ready(in_ready), .flush(flush), .cdb_req(cdb_req), .cdb_gnt(cdb_gnt),
    .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_name(cdb_name), .cdb_data(cdb_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tg, input logic [NAME_W-1:0] nm,
                       input logic [31:0] exp, input bit acc);
    in_valid = 1; in_op = op; in_opnd_a = a; in_opnd_b = b; in_tag = tg; in_name = nm;
    if (acc) sb.push_back('{tag: tg, name: nm, data: exp});
  endtask
  task automatic idle();
    in_valid = 0;
  endtask
  // monitor: every broadcast must match the oldest expected result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && cdb_en) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_broadcast: got tag %h data %h expected none", cdb_tag, cdb_data);
        end else begin
          e = sb.pop_front();
          chk("cdb_tag", 32'(cdb_tag), 32'(e.tag));
          chk("cdb_name", 32'(cdb_name), 32'(e.name));
          chk("cdb_data", cdb_data, e.data);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    #3;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_cdb_req", 32'(cdb_req), 0);
    chk("rst_cdb_en", 32'(cdb_en), 0);
    chk("rst_cdb_tag", 32'(cdb_tag), 32'(FREE_TAG));
    chk("rst_cdb_name", 32'(cdb_name), 0);
    chk("rst_cdb_data", cdb_data, 0);
    step(); step(); rst = 1;
    // single ADD, grant held
    cdb_gnt = 1;
    drive(OP_ADD, 32'hFFFF_FFFF, 32'd2, 4'd3, 5'd5, 32'h0000_0001, 1);
    step(); idle();
    chk("add_req", 32'(cdb_req), 1);
    step();
    chk("add_req_drop", 32'(cdb_req), 0);
    // shift / compare ops in order
    drive(OP_SRA, 32'h8000_0000, 32'h0000_0024, 4'd1, 5'd1, 32'hF800_0000, 1); step();
    drive(OP_SLT, 32'hFFFF_FFFF, 32'd1, 4'd2, 5'd2, 32'd1, 1); step();
    drive(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 4'd3, 5'd3, 32'd0, 1); step();
    drive(OP_SLL, 32'h0000_0003, 32'h0000_0021, 4'd4, 5'd4, 32'h0000_0006, 1); step();
    drive(OP_SUB, 32'd0, 32'd1, 4'd5, 5'd6, 32'hFFFF_FFFF, 1); step();
    drive(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd6, 5'd7, 32'h0FF0_0FF0, 1); step();
    drive(OP_LUI, 32'h1234_5678, 32'hABCD_0000, 4'd7, 5'd8, 32'hABCD_0000, 1); step();
    drive(5'd31, 32'h1, 32'h1, 4'd8, 5'd9, 32'd0, 1); step();
    idle(); step(); step();
    chk("ops_drained", 32'(cdb_req), 0);
    // fill with grant low, fifth ignored
    cdb_gnt = 0;
    for (int i = 1; i <= 4; i++) begin
      drive(OP_OR, 32'(i), 32'd0, 4'(i), 5'(i), 32'(i), 1);
      step();
    end
    chk("full_in_ready", 32'(in_ready), 0);
    drive(OP_ADD, 32'd5, 32'd0, 4'd5, 5'd5, 32'd5, 0);
    step(); idle();
    chk("full_hold", 32'(in_ready), 0);
    cdb_gnt = 1;
    step();
    chk("full_pop_ready", 32'(in_ready), 1);
    step(); step(); step();
    chk("full_drained", 32'(cdb_req), 0);
    // streaming at count=2 with wraparound
    cdb_gnt = 0;
    drive(OP_ADD, 32'd1, 32'd100, 4'd1, 5'd1, 32'd101, 1); step();
    drive(OP_ADD, 32'd2, 32'd100, 4'd2, 5'd2, 32'd102, 1); step();
    cdb_gnt = 1;
    for (int i = 3; i <= 12; i++) begin
      drive(OP_ADD, 32'(i), 32'd100, 4'(i), 5'(i), 32'(i + 100), 1);
      step();
      chk("stream_ready", 32'(in_ready), 1);
    end
    idle(); step(); step();
    chk("stream_drained", 32'(cdb_req), 0);
    // flush with grant and issue in the same cycle
    cdb_gnt = 0;
    for (int i = 1; i <= 3; i++) begin
      drive(OP_AND, 32'hFFFF_FFFF, 32'(i), 4'(i), 5'(i), 32'(i), 1);
      step();
    end
    drive(OP_ADD, 32'd4, 32'd0, 4'd4, 5'd4, 32'd4, 0);
    flush = 1; cdb_gnt = 1; sb.delete();
    #1;
    chk("flush_en", 32'(cdb_en), 0);
    step(); flush = 0; idle();
    chk("flush_req", 32'(cdb_req), 0);
    chk("flush_ready", 32'(in_ready), 1);
    step(); step();
    // async reset mid-stream
    cdb_gnt = 0;
    drive(OP_ADD, 32'd9, 32'd0, 4'd9, 5'd9, 32'd9, 1); step();
    drive(OP_ADD, 32'd10, 32'd0, 4'd10, 5'd10, 32'd10, 1); step();
    idle();
    #2;
    rst = 0; cdb_gnt = 1; sb.delete();
    #1;
    chk("arst_req", 32'(cdb_req), 0);
    chk("arst_en", 32'(cdb_en), 0);
    chk("arst_tag", 32'(cdb_tag), 32'(FREE_TAG));
    step(); rst = 1;
    drive(OP_ADD, 32'd1, 32'd1, FREE_TAG, 5'd1, 32'd2, 0); step();
    drive(OP_NOP, 32'd1, 32'd1, 4'd6, 5'd1, 32'd0, 0); step();
    idle(); step(); step();
    chk("post_rst_req", 32'(cdb_req), 0);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_cdb.md
Name: alu_exec_cdb

Overview:
- Execution stage directly downstream of the ALU reservation station.
- Takes one issued ALU operation per cycle (operands, opcode, destination tag and register name) and computes the 32-bit result in the same cycle.
- Buffers results in a small in-order result queue and arbitrates onto the common data bus (CDB) with a request/grant handshake.
- Back-pressures the reservation station when the queue is full; a flush input discards all in-flight results.

Parameters:
- DATA_W, 32, operand/result width
- TAG_W, 4, reservation-station tag width
- NAME_W, 5, architectural register name width
- OP_W, 5, opcode width
- DEPTH, 4, result queue entries (power of two, >=2)
- FREE_TAG, 0, tag value meaning "no tag"; never broadcast

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  issue strobe from reservation station
- in_op  in  OP_W  opcode (shared ALU opcode encoding)
- in_opnd_a  in  DATA_W  operand 1
- in_opnd_b  in  DATA_W  operand 2
- in_tag  in  TAG_W  destination tag (RS slot index)
- in_name  in  NAME_W  destination register name
- in_ready  out  1  block can accept an issue this cycle
- flush  in  1  synchronous discard of all buffered results (mispredict)
- cdb_req  out  1  request for the CDB
- cdb_gnt  in  1  CDB grant from arbiter
- cdb_en  out  1  broadcast valid (cdb_req & cdb_gnt & !flush)
- cdb_tag  out  TAG_W  broadcast tag
- cdb_name  out  NAME_W  broadcast register name
- cdb_data  out  DATA_W  broadcast result

Behaviour:
- Reset (rst=0, async): queue emptied (head = tail = count = 0), all entries' tag = FREE_TAG, name = 0, data = 0.
  - Outputs: in_ready=1, cdb_req=0, cdb_en=0, cdb_tag=FREE_TAG, cdb_name=0, cdb_data=0.
  - Reset mid-operation drops every buffered result; nothing is broadcast after release until a new issue.
- Accept: push = in_valid & in_ready & !flush & in_op != NOP & in_tag != FREE_TAG. Otherwise the issue is ignored.
- Ops (combinational on inputs, captured at push):
  - ADD/SUB: wrap mod 2^DATA_W.
  - SLL/SRL/SRA: shift amount is opnd_b[4:0]; SRA is arithmetic.
  - SLT: signed compare; SLTU: unsigned compare; both yield 0 or 1 zero-extended.
  - AND/OR/XOR: bitwise.
  - LUI/PASS: result = opnd_b.
  - Undefined opcode: result = 0, still broadcast.
- Latency: issue sampled at edge N → cdb_req=1 in cycle N+1. Broadcast occurs in the first cycle at or after N+1 with cdb_gnt=1. Minimum issue-to-CDB latency is 1 cycle.
- Queue: circular FIFO, in-order broadcast; head/tail wrap modulo DEPTH.
  - count: 0..DEPTH.
  - in_ready = (count != DEPTH); combinational, with no same-cycle bypass on pop.
  - cdb_req = (count != 0).
  - cdb_tag/cdb_name/cdb_data are driven combinationally from the head entry; when count = 0 they show FREE_TAG/0/0.
  - pop = cdb_req & cdb_gnt & !flush at posedge.
- Simultaneous push and pop: count unchanged, head and tail both advance. Legal at any count in 1..DEPTH-1.
- Full (count = DEPTH): in_ready=0; an in_valid in that cycle is ignored. The RS must hold the instruction.
- Empty: cdb_gnt is ignored, cdb_en=0.
- flush=1:
  - cdb_en is forced 0 in the same cycle.
  - At the next edge: count=0, head=tail=0, and any same-cycle issue is dropped.
  - flush has priority over push and pop.
- cdb_gnt may toggle arbitrarily. The head is held stable until granted; the arbiter sees cdb_req level-held.

Decomposition:
- Shared defines/package: DATA_W, TAG_W, NAME_W, OP_W, FREE_TAG value and ALU opcode constants (NOP, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI). These are the same constants the reservation station and decoder use.
- One sub-module: alu_core (pure combinational: op, a, b → result).
- Queue and handshake live in alu_exec_cdb.

Test Plan:
- Reset then issue ADD a=0xFFFF_FFFF, b=2, tag=3, name=5 with cdb_gnt held 1 → next cycle cdb_en=1, tag=3, name=5, data=0x0000_0001; following cycle cdb_req=0.
- SRA a=0x8000_0000, b=0x0000_0024; SLT a=0xFFFF_FFFF, b=1; SLTU with same operands → data 0xF800_0000, 1, 0, broadcast in issue order.
- cdb_gnt=0, four issues tags 1..4 → in_ready falls after the 4th; a 5th issue with tag 5 is ignored. Then cdb_gnt=1 → tags 1,2,3,4 broadcast on consecutive cycles and tag 5 never appears.
- Queue at count=2 with cdb_gnt=1 and an issue every cycle for 10 cycles → count stays 2, all 10 tags broadcast in order, and head/tail wrap past DEPTH correctly.
- Count=3 and flush=1 coinciding with cdb_gnt=1 and in_valid=1 → cdb_en=0 that cycle; next cycle cdb_req=0, in_ready=1, and no later broadcast of those entries.
- Assert rst=0 mid-stream with count=2 → cdb_req, cdb_en and cdb_tag fall immediately (asynchronously) to 0/0/FREE_TAG. After release, in_valid with tag=FREE_TAG or op=NOP → no broadcast.
